// File: rtl/icache_direct_pkg.sv
// icache_direct_pkg: geometry, address split and frame types for the direct-mapped instruction cache
package icache_direct_pkg;
   localparam int SETS  = 16;
   localparam int WORDS = 2;
   localparam int IBITS = $clog2(SETS);
   localparam int WBITS = $clog2(WORDS);
   localparam int CBITS = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int TBITS = 32 - IBITS - WBITS - 2;

   typedef logic [31:0] word_t;

   typedef enum logic {COMPARE, FETCH} icache_state_t;

   typedef struct packed {
      logic [TBITS-1:0] tag;
      logic [IBITS-1:0] idx;
      logic [WBITS-1:0] woff;
      logic [1:0]       bytoff;
   } icache_addr_t;

   typedef struct packed {
      logic              valid;
      logic [TBITS-1:0]  tag;
      word_t [WORDS-1:0] data;
   } icache_frame_t;
endpackage

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with block refill over a blocking memory port
module icache_direct
   import icache_direct_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
);
   icache_state_t    state;
   logic [CBITS-1:0] cnt;
   word_t            fill;
   icache_frame_t    frames [SETS];
   icache_addr_t     a, f;
   logic             hit, miss, take, last;
   logic             unused_bits;

   assign a = imemaddr;
   assign f = fill;
   assign unused_bits = ^{a.bytoff, f.woff, f.bytoff};

   // hit compare, fill handshake and output decode
   always_comb begin
      hit      = state == COMPARE && imemREN && frames[a.idx].valid && frames[a.idx].tag == a.tag;
      miss     = state == COMPARE && imemREN && !hit;
      take     = state == FETCH && !iwait;
      last     = take && cnt == CBITS'(WORDS - 1);
      ihit     = hit;
      imemload = frames[a.idx].data[a.woff];
      iREN     = state == FETCH;
      iaddr    = fill + 32'({cnt, 2'b00});
   end

   // FSM, word counter and latched block base address
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state <= COMPARE;
         cnt   <= '0;
         fill  <= '0;
      end else if (miss) begin
         state <= FETCH;
         cnt   <= '0;
         fill  <= {imemaddr[31:WBITS+2], {(WBITS+2){1'b0}}};
      end else if (last) begin
         state <= COMPARE;
         cnt   <= '0;
      end else if (take)
         cnt <= cnt + 1'b1;

   // frame array: only valid bits are reset; a miss invalidates the frame until its fill completes
   always_ff @(posedge CLK or posedge RST)
      if (RST)
         for (int i = 0; i < SETS; i++) frames[i].valid <= 1'b0;
      else if (miss)
         frames[a.idx].valid <= 1'b0;
      else if (take) begin
         frames[f.idx].data[cnt[WBITS-1:0]] <= iload;
         if (last) begin
            frames[f.idx].tag   <= f.tag;
            frames[f.idx].valid <= 1'b1;
         end
      end
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: scoreboard bench for icache_direct with a 2-wait-state memory model
module tb_icache_direct;
   logic        clk = 0, rst = 0, imemREN = 0, ihit, iREN, iwait;
   logic [31:0] imemaddr = 0, imemload, iaddr, iload;
   int          vectors = 0, miscompares = 0;
   int          wcnt = 0;
   logic [31:0] exp_addr_q[$], exp_data_q[$];
   logic [31:0] ea, ed;

   icache_direct dut (
      .CLK(clk), .RST(rst), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
      .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // memory: two busy cycles, then the word is offered for one cycle
   assign iwait = !(iREN && wcnt == 2);
   assign iload = memf(iaddr);
   always @(posedge clk or posedge rst)
      if (rst || !iREN) wcnt <= 0;
      else wcnt <= (wcnt == 2) ? 0 : wcnt + 1;

   // monitor: hit data and accepted memory addresses are checked against the scoreboard queues
   always @(negedge clk) begin
      if (imemREN && ihit) begin
         vectors++;
         if (exp_data_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_hit addr=%h data=%h", imemaddr, imemload);
         end else begin
            ed = exp_data_q.pop_front();
            if (imemload !== ed) begin
               miscompares++;
               $display("FAIL hit_data addr=%h got=%h want=%h", imemaddr, imemload, ed);
            end
         end
      end
      if (iREN && !iwait) begin
         vectors++;
         if (exp_addr_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_fetch iaddr=%h", iaddr);
         end else begin
            ea = exp_addr_q.pop_front();
            if (iaddr !== ea) begin
               miscompares++;
               $display("FAIL fetch_addr got=%h want=%h", iaddr, ea);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic issue(input logic [31:0] a);
      @(posedge clk); #1;
      imemREN  = 1;
      imemaddr = a;
   endtask

   task automatic exp_fill(input logic [31:0] base);
      exp_addr_q.push_back(base);
      exp_addr_q.push_back(base + 4);
   endtask

   task automatic wait_hit(input string name, input int lat);
      int n = 0;
      @(negedge clk);
      while (!ihit && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (!ihit) begin
         vectors++;
         miscompares++;
         $display("FAIL %s timeout waiting for ihit", name);
      end else
         check(name, n, lat);
   endtask

   task automatic access(input string name, input logic [31:0] a, input bit is_miss);
      issue(a);
      if (is_miss) exp_fill({a[31:3], 3'b000});
      exp_data_q.push_back(memf(a));
      wait_hit(name, is_miss ? 7 : 0);
   endtask

   initial begin
      rst = 1;
      #1;
      check("reset_ihit", ihit, 0);
      check("reset_iren", iREN, 0);
      check("reset_iaddr", iaddr, 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      // T1 cold miss, T2 block-mate hit
      access("t1_cold_miss_lat", 32'h00, 1);
      access("t2_mate_hit_lat", 32'h04, 0);
      check("t2_iren_idle", iREN, 0);
      // T3 conflict eviction
      access("t3_conflict_lat", 32'h80, 1);
      access("t3_evicted_lat", 32'h00, 1);
      // T4 address change during fill
      issue(32'h10);
      exp_fill(32'h10);
      exp_fill(32'h20);
      exp_data_q.push_back(memf(32'h20));
      @(posedge clk); #1;
      imemaddr = 32'h20;
      wait_hit("t4_refetch_lat", 13);
      access("t4_first_block_hit", 32'h10, 0);
      // T5 reset with counter=1
      issue(32'h40);
      exp_addr_q.push_back(32'h40);
      repeat (4) @(posedge clk);
      #1 rst = 1;
      #1;
      check("t5_iren_in_reset", iREN, 0);
      check("t5_ihit_in_reset", ihit, 0);
      imemREN = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      access("t5_refill_after_reset", 32'h10, 1);
      access("t5_partial_invalid", 32'h40, 1);
      // T6 idle
      @(posedge clk); #1;
      imemREN = 0;
      for (int i = 0; i < 10; i++) begin
         imemaddr = {$urandom_range(0, 255), 2'b00};
         @(negedge clk);
         check("t6_idle_ihit", ihit, 0);
         check("t6_idle_iren", iREN, 0);
      end
      access("t6_state_kept", 32'h14, 0);
      @(posedge clk); #1;
      imemREN = 0;
      repeat (2) @(posedge clk);
      check("leftover_fetches", exp_addr_q.size(), 0);
      check("leftover_hits", exp_data_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
